// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared op encodings and multiply/divide FSM state type
package mips_pkg;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      ITER = 2'b01,
      FIX  = 2'b10
   } mdu_state_e;

   function automatic logic is_signed_op(input logic [1:0] op);
      return (op == OP_MULT) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// rtl/mult_div_unit_if.sv - start/busy/done handshake and HI/LO result bundle
interface mult_div_unit_if #(parameter int WIDTH = 32);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic             div_zero;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (output start, op, a, b, input busy, done, div_zero, hi, lo);
   modport slave  (input start, op, a, b, output busy, done, div_zero, hi, lo);
endinterface

// File: rtl/mdu_sign_fix.sv
// rtl/mdu_sign_fix.sv - operand magnitudes at load and result sign correction at fix
module mdu_sign_fix
   import mips_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [1:0]         ld_op,
   input  logic [WIDTH-1:0]   ld_a,
   input  logic [WIDTH-1:0]   ld_b,
   output logic [WIDTH-1:0]   mag_a,
   output logic [WIDTH-1:0]   mag_b,
   output logic               sign_a,
   output logic               sign_b,
   input  logic               fx_is_div,
   input  logic               fx_sign_a,
   input  logic               fx_sign_b,
   input  logic [2*WIDTH-1:0] acc,
   output logic [WIDTH-1:0]   hi_res,
   output logic [WIDTH-1:0]   lo_res
);

   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   quot;
   logic [WIDTH-1:0]   rem;

   always_comb begin
      sign_a = is_signed_op(ld_op) & ld_a[WIDTH-1];
      sign_b = is_signed_op(ld_op) & ld_b[WIDTH-1];
      mag_a  = sign_a ? -ld_a : ld_a;
      mag_b  = sign_b ? -ld_b : ld_b;
   end

   // Signs are latched only for signed ops, so unsigned results pass through untouched.
   always_comb begin
      prod = (fx_sign_a ^ fx_sign_b) ? -acc : acc;
      quot = (fx_sign_a ^ fx_sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      rem  = fx_sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      if (fx_is_div) begin
         hi_res = rem;
         lo_res = quot;
      end else begin
         hi_res = prod[2*WIDTH-1:WIDTH];
         lo_res = prod[WIDTH-1:0];
      end
   end

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative MULT/MULTU/DIV/DIVU unit producing HI/LO
module mult_div_unit
   import mips_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic           clk,
   input  logic           reset,
   mult_div_unit_if.slave bus
);

   localparam int CW = $clog2(WIDTH + 1);

   mdu_state_e         state;
   logic               is_div_r;
   logic               sign_a_r;
   logic               sign_b_r;
   logic               dz_r;
   logic [WIDTH-1:0]   mag_b_r;
   logic [2*WIDTH-1:0] acc;
   logic [CW-1:0]      cnt;

   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;
   logic               sign_a;
   logic               sign_b;
   logic [WIDTH-1:0]   hi_res;
   logic [WIDTH-1:0]   lo_res;
   logic [WIDTH:0]     sum;
   logic [WIDTH:0]     rem_sh;
   logic [WIDTH:0]     diff;
   logic [2*WIDTH-1:0] acc_next;

   mdu_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
      .ld_op     (bus.op),
      .ld_a      (bus.a),
      .ld_b      (bus.b),
      .mag_a     (mag_a),
      .mag_b     (mag_b),
      .sign_a    (sign_a),
      .sign_b    (sign_b),
      .fx_is_div (is_div_r),
      .fx_sign_a (sign_a_r),
      .fx_sign_b (sign_b_r),
      .acc       (acc),
      .hi_res    (hi_res),
      .lo_res    (lo_res)
   );

   // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
   always_comb begin
      sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_b_r} : '0);
      rem_sh = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      diff   = rem_sh - {1'b0, mag_b_r};
      if (!is_div_r)
         acc_next = {sum, acc[WIDTH-1:1]};
      else if (diff[WIDTH])
         acc_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else
         acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         is_div_r     <= 1'b0;
         sign_a_r     <= 1'b0;
         sign_b_r     <= 1'b0;
         dz_r         <= 1'b0;
         mag_b_r      <= '0;
         acc          <= '0;
         cnt          <= '0;
         bus.busy     <= 1'b0;
         bus.done     <= 1'b0;
         bus.div_zero <= 1'b0;
         bus.hi       <= '0;
         bus.lo       <= '0;
      end else begin
         bus.done <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  is_div_r <= bus.op[1];
                  sign_a_r <= sign_a;
                  sign_b_r <= sign_b;
                  mag_b_r  <= mag_b;
                  acc      <= {{WIDTH{1'b0}}, mag_a};
                  cnt      <= '0;
                  dz_r     <= bus.op[1] && (bus.b == '0);
                  bus.busy <= 1'b1;
                  state    <= (bus.op[1] && (bus.b == '0)) ? FIX : ITER;
               end
            end
            ITER: begin
               acc <= acc_next;
               cnt <= cnt + CW'(1);
               if (cnt == CW'(WIDTH - 1))
                  state <= FIX;
            end
            FIX: begin
               if (dz_r) begin
                  bus.div_zero <= 1'b1;
               end else begin
                  bus.div_zero <= 1'b0;
                  bus.hi       <= hi_res;
                  bus.lo       <= lo_res;
               end
               bus.done <= 1'b1;
               bus.busy <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
